// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default line constants, receiver
// FSM state encoding and the tick divider calculation. Imported by the
// receiver, the transmitter and the controller.
package uart_pkg;

    localparam int WORD_SIZE          = 8;
    localparam int CLK_FREQ_DEFAULT   = 50_000_000;
    localparam int BAUD_RATE_DEFAULT  = 115_200;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Clocks per sample tick; never below one so the tick is always defined.
    function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversample);
        int div;
        div = clk_freq / (baud_rate * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: serial line in, received word and its
// availability strobe out. master = receiver, slave = line driver/consumer.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                 rx;
    logic [WORD_SIZE-1:0] data_read;
    logic                 rx_avbl_i;

    modport master (
        input  rx,
        output data_read,
        output rx_avbl_i
    );

    modport slave (
        output rx,
        input  data_read,
        input  rx_avbl_i
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick divider. tick is high for one clk every
// tick_div() clks; restart forces the count back to zero so the next tick
// lands a full period later. Used with OVERSAMPLE=1 by the transmitter.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int             DIV  = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: wraps at LAST, or jumps to zero on restart.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receive engine, 8N1 framing, LSB first, oversampled mid-bit
// sampling. Good words appear on data_read with a one-clk rx_avbl_i
// strobe; glitches, framing errors and (optionally) parity errors are
// dropped silently.
// Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.master bus
);

    localparam int              TCW       = $clog2(OVERSAMPLE + 1);
    localparam int              BCW       = $clog2(WORD_SIZE + 1);
    localparam logic [TCW-1:0]  HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0]  FULL_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0]  BIT_LAST  = BCW'(WORD_SIZE - 1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick;
    logic                 restart;
    logic                 parity_ok;

    uart_state_e          state_q,    state_d;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BCW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [WORD_SIZE-1:0] shift_q,    shift_d;
    logic [WORD_SIZE-1:0] data_q,     data_d;
    logic                 avbl_q,     avbl_d;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_q, parity_bad_d;
`endif

    // Two-flop synchronizer for the asynchronous serial line.
    // NOTE: the flops reset to 1 (idle line level) so leaving reset never
    // looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rx};
        end
    end

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

`ifdef UART_RX_PARITY_EN
    assign parity_ok = !parity_bad_q;
`else
    assign parity_ok = 1'b1;
`endif

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            avbl_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            avbl_q       <= avbl_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    // Next-state and datapath decode; samples are taken on the tick that
    // closes each half-bit (start) or full-bit (data, parity, stop) interval.
    always_comb begin
        // NOTE: every output is given a default first so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        avbl_d     = 1'b0;
        restart    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                parity_bad_d = 1'b0;
`endif
                if (!rx_s) begin
                    state_d = START;
                    restart = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[WORD_SIZE-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d   = '0;
                        parity_bad_d = ^{shift_q, rx_s};
                        state_d      = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            // Leave at mid-stop so a back-to-back start bit is caught.
                            state_d = IDLE;
                            if (parity_ok) begin
                                data_d = shift_q;
                                avbl_d = 1'b1;
                            end
                        end else begin
                            state_d = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_read = data_q;
    assign bus.rx_avbl_i = avbl_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 6.4 MHz / 100 kbaud (64 clks
// per bit). A queue of expected words drives a per-cycle compare process;
// literal checks after each scenario pin the queue model itself.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_STROBES = 6;
`else
    localparam int EXP_STROBES = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLK_FREQ   (6_400_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         n_strobes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_last = 8'h00;
    logic       prev_avbl  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!rst) begin
            model_last = 8'h00;
            exp_q.delete();
            check("reset_avbl", 32'(bus.rx_avbl_i), 32'd0);
            check("reset_data", 32'(bus.data_read), 32'd0);
        end else if (bus.rx_avbl_i) begin
            n_strobes++;
            check("double_strobe", 32'(prev_avbl), 32'd0);
            check("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                model_last = exp_q.pop_front();
                check("strobe_data", 32'(bus.data_read), 32'(model_last));
            end
        end else begin
            check("data_hold", 32'(bus.data_read), 32'(model_last));
        end
        prev_avbl = bus.rx_avbl_i;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        bus.rx = v;
        wait_clks(BIT_CLKS);
    endtask

    // One frame; the word is expected only with a good stop bit and parity.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        logic good;
        good = stop_v && !par_flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        if (good) exp_q.push_back(d);
        send_bit(stop_v);
        if (good) check("strobe_deadline", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.rx = 1'b1;
        #1 rst = 1'b0;

        // Reset held with the line toggling.
        for (int i = 0; i < 8; i++) begin
            bus.rx = i[0];
            wait_clks(5);
        end
        bus.rx = 1'b1;
        wait_clks(2);
        rst = 1'b1;
        wait_clks(200);
        check("post_reset_data", 32'(bus.data_read), 32'h00);

        // Single frame, then back-to-back with zero idle gap.
        send_frame(8'hA5, 1'b1, 1'b0);
        check("lit_a5", 32'(bus.data_read), 32'hA5);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("lit_3c", 32'(bus.data_read), 32'h3C);

        // 20-clk glitch on the idle line.
        wait_clks(BIT_CLKS);
        bus.rx = 1'b0;
        wait_clks(20);
        bus.rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_hold", 32'(bus.data_read), 32'h3C);
        send_frame(8'h55, 1'b1, 1'b0);
        check("lit_55", 32'(bus.data_read), 32'h55);

        // Framing error followed by a held-low line.
        wait_clks(BIT_CLKS);
        send_frame(8'h81, 1'b0, 1'b0);
        bus.rx = 1'b0;
        wait_clks(200);
        bus.rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("framing_hold", 32'(bus.data_read), 32'h55);
        send_frame(8'h7E, 1'b1, 1'b0);
        check("lit_7e", 32'(bus.data_read), 32'h7E);

        // Reset during data bit 4 of 0xFF.
        wait_clks(BIT_CLKS);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus.rx = 1'b1;
        wait_clks(10);
        rst = 1'b0;
        wait_clks(20);
        rst = 1'b1;
        wait_clks(BIT_CLKS - 30);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("reset_mid_data", 32'(bus.data_read), 32'h00);
        send_frame(8'h00, 1'b1, 1'b0);
        check("lit_00", 32'(bus.data_read), 32'h00);

`ifdef UART_RX_PARITY_EN
        // Even parity accepted, odd parity dropped.
        wait_clks(BIT_CLKS);
        send_frame(8'h03, 1'b1, 1'b0);
        check("lit_par_ok", 32'(bus.data_read), 32'h03);
        send_frame(8'h03, 1'b1, 1'b1);
        check("lit_par_bad", 32'(bus.data_read), 32'h03);
`endif

        wait_clks(BIT_CLKS);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("strobe_count", 32'(n_strobes), 32'(EXP_STROBES));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
